// File: rtl/ssd_scan_ctrl_if.sv
// Producer-to-scan-controller byte handshake (valid/ready plus the data byte).
interface ssd_scan_ctrl_if;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] data_i;

   modport master (output valid_i, output data_i, input ready_o);
   modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Two-digit 7-segment scan scheduler: alternates digit phases and commits new values only at frame ends.
// Optional blinking is built when the macro SSD_BLINK_EN is defined.
module ssd_scan_ctrl #(
   parameter int TICKS_PER_DIGIT = 120_000,
   parameter int BLINK_FRAMES    = 25
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   ssd_scan_ctrl_if.slave bus,
   input  logic           blink_i,
   output logic           digit_sel_o,
   output logic [3:0]     right_digit_o,
   output logic [3:0]     left_digit_o,
   output logic           blank_o,
   output logic           frame_o
);
   localparam int CntW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_DIGIT - 1);

   typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} phase_e;

   phase_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pending_q, pending_d;
   logic [7:0]      pendData_q, pendData_d;
   logic [7:0]      shown_q, shown_d;
   logic            loaded_q, loaded_d;
   logic            frame_q;
   logic            wrap, frameEnd, accept;

   assign wrap        = (cnt_q == CntMax);
   assign frameEnd    = wrap & (state_q == LEFT);
   assign bus.ready_o = ~pending_q;
   assign accept      = bus.valid_i & ~pending_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= RIGHT;
         cnt_q      <= '0;
         pending_q  <= 1'b0;
         pendData_q <= 8'h00;
         shown_q    <= 8'h00;
         loaded_q   <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         pendData_q <= pendData_d;
         shown_q    <= shown_d;
         loaded_q   <= loaded_d;
         frame_q    <= frameEnd;
      end
   end

   always_comb begin
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      state_d = state_q;
      if (wrap) begin
         state_d = (state_q == RIGHT) ? LEFT : RIGHT;
      end
   end

   // A value accepted on the frame-end cycle itself is still only pending, so it waits a full frame.
   always_comb begin
      pending_d  = pending_q;
      pendData_d = pendData_q;
      shown_d    = shown_q;
      loaded_d   = loaded_q;
      if (frameEnd && pending_q) begin
         shown_d   = pendData_q;
         pending_d = 1'b0;
         loaded_d  = 1'b1;
      end else if (accept) begin
         pendData_d = bus.data_i;
         pending_d  = 1'b1;
      end
   end

   assign digit_sel_o   = state_q;
   assign right_digit_o = shown_q[3:0];
   assign left_digit_o  = shown_q[7:4];
   assign frame_o       = frame_q;

`ifdef SSD_BLINK_EN
   localparam int FrW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FrW-1:0] FrMax = FrW'(BLINK_FRAMES - 1);

   logic [FrW-1:0] frameCnt_q, frameCnt_d;
   logic           blinkPh_q, blinkPh_d;

   always_comb begin
      frameCnt_d = frameCnt_q;
      blinkPh_d  = blinkPh_q;
      if (!blink_i) begin
         frameCnt_d = '0;
         blinkPh_d  = 1'b0;
      end else if (frameEnd) begin
         if (frameCnt_q == FrMax) begin
            frameCnt_d = '0;
            blinkPh_d  = ~blinkPh_q;
         end else begin
            frameCnt_d = frameCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         frameCnt_q <= '0;
         blinkPh_q  <= 1'b0;
      end else begin
         frameCnt_q <= frameCnt_d;
         blinkPh_q  <= blinkPh_d;
      end
   end

   assign blank_o = ~loaded_q | (blink_i & blinkPh_q);
`else
   logic unusedBlink;
   assign unusedBlink = blink_i;
   assign blank_o     = ~loaded_q;
`endif
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed scoreboard bench for ssd_scan_ctrl; a second instance covers TICKS_PER_DIGIT=1.
`timescale 1ns/1ps
module tb_ssd_scan_ctrl;
   localparam int Ticks    = 4;
   localparam int Frames   = 2;
   localparam int FrameLen = 2 * Ticks;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       blink = 1'b0;
   logic       digitSel, blank, frame;
   logic [3:0] rightDigit, leftDigit;
   logic       digitSel1, blank1, frame1;
   logic [3:0] rightDigit1, leftDigit1;

   ssd_scan_ctrl_if busIf();
   ssd_scan_ctrl_if busIf1();

   ssd_scan_ctrl #(.TICKS_PER_DIGIT(Ticks), .BLINK_FRAMES(Frames)) dut (
      .clk_i(clk), .reset_ni(resetN), .bus(busIf), .blink_i(blink),
      .digit_sel_o(digitSel), .right_digit_o(rightDigit), .left_digit_o(leftDigit),
      .blank_o(blank), .frame_o(frame));

   ssd_scan_ctrl #(.TICKS_PER_DIGIT(1), .BLINK_FRAMES(Frames)) dut1 (
      .clk_i(clk), .reset_ni(resetN), .bus(busIf1), .blink_i(1'b0),
      .digit_sel_o(digitSel1), .right_digit_o(rightDigit1), .left_digit_o(leftDigit1),
      .blank_o(blank1), .frame_o(frame1));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         commitEdge;
   } entry_t;

   entry_t     sb[$];
   int         checks = 0;
   int         errors = 0;
   int         edges = 0;
   logic [7:0] expShown = 8'h00;
   logic       expLoaded = 1'b0;
   int         blinkCnt = 0;
   logic       blinkPh = 1'b0;

   task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edges);
      end
   endtask

   task automatic checkOutput();
      logic expBlank;
`ifdef SSD_BLINK_EN
      expBlank = ~expLoaded | (blink & blinkPh);
`else
      expBlank = ~expLoaded;
`endif
      checkVal("digit_sel", 8'(digitSel), 8'((edges / Ticks) % 2));
      checkVal("frame", 8'(frame), 8'((edges > 0) && (edges % FrameLen == 0)));
      checkVal("ready", 8'(busIf.ready_o), 8'(sb.size() == 0));
      checkVal("right_digit", 8'(rightDigit), 8'(expShown[3:0]));
      checkVal("left_digit", 8'(leftDigit), 8'(expShown[7:4]));
      checkVal("blank", 8'(blank), 8'(expBlank));
      checkVal("t1_digit_sel", 8'(digitSel1), 8'(edges % 2));
      checkVal("t1_frame", 8'(frame1), 8'((edges > 0) && (edges % 2 == 0)));
      checkVal("t1_idle", {leftDigit1, rightDigit1}, 8'h00);
      checkVal("t1_blank_ready", {6'd0, blank1, busIf1.ready_o}, 8'h03);
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data);
      busIf.valid_i = valid;
      busIf.data_i  = data;
   endtask

   // Advances n clocks, updating the reference model at each rising edge and checking on the falling edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         bit     wasReady;
         entry_t e;
         wasReady = (sb.size() == 0);
         @(posedge clk);
         edges++;
         if (sb.size() > 0 && sb[0].commitEdge == edges) begin
            e         = sb.pop_front();
            expShown  = e.data;
            expLoaded = 1'b1;
         end
         if (busIf.valid_i && wasReady) begin
            e.data       = busIf.data_i;
            e.commitEdge = (edges / FrameLen + 1) * FrameLen;
            sb.push_back(e);
         end
         if (!blink) begin
            blinkCnt = 0;
            blinkPh  = 1'b0;
         end else if (edges % FrameLen == 0) begin
            if (blinkCnt == Frames - 1) begin
               blinkCnt = 0;
               blinkPh  = ~blinkPh;
            end else begin
               blinkCnt++;
            end
         end
         @(negedge clk);
         checkOutput();
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      resetN = 1'b0;
      applyStimulus(1'b0, 8'h00);
      blink = 1'b0;
      #1;
      sb.delete();
      edges     = 0;
      expShown  = 8'h00;
      expLoaded = 1'b0;
      blinkCnt  = 0;
      blinkPh   = 1'b0;
      checkOutput();
      @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      busIf.valid_i  = 1'b0;
      busIf.data_i   = 8'h00;
      busIf1.valid_i = 1'b0;
      busIf1.data_i  = 8'h00;

      $display("[TB] test 1: reset and idle");
      doReset();
      step(40);
      checkVal("t1_blank_idle", 8'(blank), 8'h01);

      $display("[TB] test 2: accept 3A in right phase");
      step(2);
      applyStimulus(1'b1, 8'h3A);
      step(1);
      applyStimulus(1'b0, 8'h00);
      checkVal("t2_ready_low", 8'(busIf.ready_o), 8'h00);
      step(12);
      checkVal("t2_digits", {leftDigit, rightDigit}, 8'h3A);
      checkVal("t2_blank", 8'(blank), 8'h00);

      $display("[TB] test 3: accept 12 on frame end");
      for (int g = 0; g < FrameLen && (edges % FrameLen) != FrameLen - 1; g++) step(1);
      applyStimulus(1'b1, 8'h12);
      step(1);
      applyStimulus(1'b0, 8'h00);
      step(7);
      checkVal("t3_not_yet", {leftDigit, rightDigit}, 8'h3A);
      step(1);
      checkVal("t3_shown", {leftDigit, rightDigit}, 8'h12);

      $display("[TB] test 4: hold valid while pending");
      applyStimulus(1'b1, 8'h55);
      step(1);
      applyStimulus(1'b1, 8'h66);
      step(7);
      checkVal("t4_first", {leftDigit, rightDigit}, 8'h55);
      step(1);
      applyStimulus(1'b0, 8'h00);
      step(8);
      checkVal("t4_second", {leftDigit, rightDigit}, 8'h66);

      $display("[TB] test 5: reset mid-left-phase with 77 pending");
      applyStimulus(1'b1, 8'h77);
      step(1);
      applyStimulus(1'b0, 8'h00);
      step(3);
      checkVal("t5_in_left", 8'(digitSel), 8'h01);
      doReset();
      step(16);
      checkVal("t5_never_shown", {leftDigit, rightDigit}, 8'h00);

`ifdef SSD_BLINK_EN
      $display("[TB] test 6: blinking");
      applyStimulus(1'b1, 8'hA5);
      step(1);
      applyStimulus(1'b0, 8'h00);
      step(16);
      blink = 1'b1;
      step(40);
      blink = 1'b0;
      step(1);
      checkVal("t6_blink_off", 8'(blank), 8'h00);
      step(4);
`endif

      checkVal("sb_empty", 8'(sb.size()), 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
